fm_dll: RTL and testbench

FM_DLL -- requirements
Module: fm_dll

---
 rtl/fm_dll_pkg.sv | 37 +++
 rtl/fm_dll_delay_cell.sv | 13 +
 rtl/fm_dll.sv | 76 +++++++
 tb/tb_fm_dll.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fm_dll_pkg.sv
// fm_dll_pkg: shared constants and N-ratio decoding for the frequency-multiplying DLL.
package fm_dll_pkg;
   timeunit 1ns;
   timeprecision 10ps;

   localparam int TAPS = 80;
   localparam int CODE_W = 7;
   localparam logic [CODE_W-1:0] COARSE_STEP = CODE_W'(4);
   localparam logic [CODE_W-1:0] FINE_STEP = CODE_W'(1);
   localparam logic [CODE_W-1:0] CODE_MAX = CODE_W'(127);

   function automatic logic [3:0] legal_n(input logic [3:0] n);
      return (n == 4'd4 || n == 4'd5 || n == 4'd8 || n == 4'd10) ? n : 4'd1;
   endfunction

   function automatic int tap_spacing(input logic [3:0] n);
      return n == 4'd4 ? 10 : n == 4'd5 ? 8 : n == 4'd8 ? 5 : n == 4'd10 ? 4 : 40;
   endfunction

   function automatic logic [TAPS-1:0] spaced_mask(input int sp);
      logic [TAPS-1:0] m;
      for (int k = 0; k < TAPS; k++) m[k] = (k % sp) == 0;
      return m;
   endfunction

   localparam logic [TAPS-1:0] MASK_N1 = spaced_mask(tap_spacing(4'd1));
   localparam logic [TAPS-1:0] MASK_N4 = spaced_mask(tap_spacing(4'd4));
   localparam logic [TAPS-1:0] MASK_N5 = spaced_mask(tap_spacing(4'd5));
   localparam logic [TAPS-1:0] MASK_N8 = spaced_mask(tap_spacing(4'd8));
   localparam logic [TAPS-1:0] MASK_N10 = spaced_mask(tap_spacing(4'd10));

   // Taps j*40/N for j=0..2N-1 are exactly the multiples of the spacing below TAPS.
   function automatic logic [TAPS-1:0] tap_mask(input logic [3:0] n);
      return n == 4'd4 ? MASK_N4 : n == 4'd5 ? MASK_N5 : n == 4'd8 ? MASK_N8 :
             n == 4'd10 ? MASK_N10 : MASK_N1;
   endfunction
endpackage

// File: rtl/fm_dll_delay_cell.sv
// fm_dll_delay_cell: one delay-line element; delay = 0.10 ns + code * 0.02 ns.
module fm_dll_delay_cell
   import fm_dll_pkg::*;
(
   input  logic              in,
   input  logic [CODE_W-1:0] code,
   output logic              out
);
   timeunit 1ns;
   timeprecision 10ps;

   assign #(0.10 + 0.02 * real'(code)) out = in;
endmodule

// File: rtl/fm_dll.sv
// fm_dll: 80-tap delay line servoed to span one M-cycle reference window;
// clk_out is the XOR of evenly spaced taps, giving f_ref * N / M.
module fm_dll
   import fm_dll_pkg::*;
(
   input  logic       clk_ext,
   input  logic       rst_n,
   input  logic [1:0] M,
   input  logic [3:0] N,
   output logic       clk_out,
   output logic [1:0] Sel
);
   timeunit 1ns;
   timeprecision 10ps;

   logic [1:0] m_q, m_d, sel_q, sel_d;
   logic [3:0] n_q, n_d;
   logic launch_q, launch_d, up_q, up_d, upd_q, upd_d;
   logic coarse_q, coarse_d, dir_q, dir_d, hist_q, hist_d;
   logic [CODE_W-1:0] code_q, code_d, step, code_inc, code_dec;
   logic [CODE_W:0] sum;
   logic bnd, rev;
   logic [TAPS:0] tap;

   assign tap[0] = launch_q;
   for (genvar i = 0; i < TAPS; i++) begin : g_cell
      fm_dll_delay_cell u_cell (.in(tap[i]), .code(code_q), .out(tap[i+1]));
   end

   assign clk_out = ^(tap[TAPS-1:0] & tap_mask(n_q));
   assign Sel = sel_q;

   always_comb begin
      m_d = (M == 2'd0) ? 2'd1 : M;
      n_d = legal_n(N);
      bnd = sel_q == m_q - 2'd1;
      sel_d = bnd ? 2'd0 : sel_q + 2'd1;
      launch_d = launch_q ^ bnd;
      // Line end still equal to the pre-toggle launch value means the edge arrived early.
      up_d = bnd ? (tap[TAPS] == launch_q) : up_q;
      upd_d = bnd;
      rev = upd_q && hist_q && (up_q != dir_q);
      step = (coarse_q && !rev) ? COARSE_STEP : FINE_STEP;
      sum = {1'b0, code_q} + {1'b0, step};
      code_inc = sum[CODE_W] ? CODE_MAX : sum[CODE_W-1:0];
      code_dec = (code_q < step) ? '0 : code_q - step;
      code_d = upd_q ? (up_q ? code_inc : code_dec) : code_q;
      coarse_d = coarse_q && !rev;
      dir_d = upd_q ? up_q : dir_q;
      hist_d = hist_q || upd_q;
   end

   always_ff @(posedge clk_ext) begin
      if (!rst_n) begin
         m_q      <= m_d;
         n_q      <= n_d;
         sel_q    <= '0;
         launch_q <= 1'b0;
         up_q     <= 1'b0;
         upd_q    <= 1'b0;
         code_q   <= '0;
         coarse_q <= 1'b1;
         dir_q    <= 1'b0;
         hist_q   <= 1'b0;
      end else begin
         sel_q    <= sel_d;
         launch_q <= launch_d;
         up_q     <= up_d;
         upd_q    <= upd_d;
         code_q   <= code_d;
         coarse_q <= coarse_d;
         dir_q    <= dir_d;
         hist_q   <= hist_d;
      end
   end
endmodule

// File: tb/tb_fm_dll.sv
// tb_fm_dll: directed bench for fm_dll with 40 ns reference clock.
module tb_fm_dll;
   timeunit 1ns;
   timeprecision 10ps;

   logic       clk_ext = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] M = 2'd3;
   logic [3:0] N = 4'd10;
   logic       clk_out;
   logic [1:0] Sel;
   int checks = 0;
   int failures = 0;
   bit rec = 1'b0;
   real rises[$];

   fm_dll dut (.clk_ext(clk_ext), .rst_n(rst_n), .M(M), .N(N), .clk_out(clk_out), .Sel(Sel));

   always #20 clk_ext = ~clk_ext;

   always @(posedge clk_out) if (rec) rises.push_back($realtime);

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input real obs, input real lo, input real hi);
      checks++;
      assert (obs >= lo && obs <= hi) else begin
         failures++;
         $error("FAIL %s observed=%0.3f expected=%0.3f..%0.3f", tag, obs, lo, hi);
      end
   endtask

   task automatic neg(input int k);
      repeat (k) @(negedge clk_ext);
   endtask

   task automatic do_reset(input logic [1:0] m, input logic [3:0] n, input int cyc);
      @(posedge clk_ext);
      #10;
      M = m;
      N = n;
      rst_n = 1'b0;
      repeat (cyc) @(posedge clk_ext);
      #10 rst_n = 1'b1;
   endtask

   // Locked span 8 + 1.6*code ns should match M*40 ns; allow the bang-bang dither.
   task automatic chk_lock(input string tag, input int m);
      real ctr;
      ctr = (40.0 * m - 8.0) / 1.6;
      chk_rng({tag, "_code"}, real'(dut.code_q), ctr - 3.0, ctr + 3.0);
      chk({tag, "_fine"}, int'(dut.coarse_q), 0);
   endtask

   task automatic measure(input string tag, input real tgt);
      real mean, dmin, dmax, d;
      rises.delete();
      rec = 1'b1;
      #960;
      rec = 1'b0;
      mean = 0.0;
      dmin = 0.0;
      dmax = 0.0;
      if (rises.size() > 1) begin
         mean = (rises[rises.size()-1] - rises[0]) / real'(rises.size() - 1);
         dmin = 1.0e9;
         for (int i = 1; i < rises.size(); i++) begin
            d = rises[i] - rises[i-1];
            if (d < dmin) dmin = d;
            if (d > dmax) dmax = d;
         end
      end
      chk_rng({tag, "_count"}, real'(rises.size()), 960.0 / tgt - 2.0, 960.0 / tgt + 2.0);
      chk_rng({tag, "_mean"}, mean, 0.95 * tgt, 1.05 * tgt);
      chk_rng({tag, "_min"}, dmin, 0.7 * tgt, 1.3 * tgt);
      chk_rng({tag, "_max"}, dmax, 0.7 * tgt, 1.3 * tgt);
   endtask

   initial begin
      int prev, step, mx;
      // N=10, M=3 under the initial 150 ns reset
      neg(1);
      chk("rst_sel", int'(Sel), 0);
      chk("rst_code", int'(dut.code_q), 0);
      chk("rst_clk_out", int'(clk_out), 0);
      #110 rst_n = 1'b1;
      neg(1); chk("a_sel_e0", int'(Sel), 0);
      neg(1); chk("a_sel_e1", int'(Sel), 1);
      neg(1); chk("a_sel_e2", int'(Sel), 2);
      neg(1); chk("a_sel_e3", int'(Sel), 0); chk("a_code_e3", int'(dut.code_q), 0);
      neg(1); chk("a_sel_e4", int'(Sel), 1); chk("a_code_e4", int'(dut.code_q), 4);
      neg(1); chk("a_sel_e5", int'(Sel), 2);
      neg(1); chk("a_sel_e6", int'(Sel), 0);
      neg(1); chk("a_code_e7", int'(dut.code_q), 8);
      #4000;
      neg(1);
      chk_lock("a", 3);
      measure("a_period", 12.0);
      // reset pulse while locked
      @(posedge clk_ext);
      #10 rst_n = 1'b0;
      @(posedge clk_ext);
      neg(1);
      chk("e_sel", int'(Sel), 0);
      chk("e_code", int'(dut.code_q), 0);
      #192;
      chk("e_clk_out_flushed", int'(clk_out), 0);
      @(posedge clk_ext);
      #10 rst_n = 1'b1;
      neg(2); chk("e_sel_e1", int'(Sel), 1);
      #4000;
      neg(1);
      chk_lock("e", 3);
      measure("e_period", 12.0);
      // N changed without reset must be ignored
      N = 4'd4;
      #400;
      neg(1);
      measure("f_period", 12.0);
      // N=4, M=1
      do_reset(2'd1, 4'd4, 8);
      neg(2); chk("b_sel_e1", int'(Sel), 0); chk("b_code_e1", int'(dut.code_q), 0);
      neg(1); chk("b_sel_e2", int'(Sel), 0); chk("b_code_e2", int'(dut.code_q), 4);
      neg(1); chk("b_sel_e3", int'(Sel), 0); chk("b_code_e3", int'(dut.code_q), 8);
      #4000;
      neg(1);
      chk_lock("b", 1);
      measure("b_period", 10.0);
      // N=5, M=2: coarse climb then unit dither
      do_reset(2'd2, 4'd5, 8);
      neg(2); chk("c_sel_e1", int'(Sel), 1);
      neg(1); chk("c_sel_e2", int'(Sel), 0); chk("c_code_e2", int'(dut.code_q), 0);
      neg(1); chk("c_sel_e3", int'(Sel), 1); chk("c_code_e3", int'(dut.code_q), 4);
      neg(1); chk("c_code_e4", int'(dut.code_q), 4);
      neg(1); chk("c_code_e5", int'(dut.code_q), 8);
      #4000;
      neg(1);
      prev = int'(dut.code_q);
      mx = 0;
      repeat (16) begin
         neg(1);
         step = int'(dut.code_q) - prev;
         if (step < 0) step = -step;
         if (step > mx) mx = step;
         prev = int'(dut.code_q);
      end
      chk("c_dither_step", mx, 1);
      chk_lock("c", 2);
      measure("c_period", 16.0);
      // illegal N=3 and M=0 behave as N=1, M=1
      do_reset(2'd0, 4'd3, 8);
      neg(2); chk("d_sel_e1", int'(Sel), 0);
      neg(1); chk("d_sel_e2", int'(Sel), 0); chk("d_code_e2", int'(dut.code_q), 4);
      #4000;
      neg(1);
      chk_lock("d", 1);
      measure("d_period", 40.0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
